alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU. Latches a decoded instruction and resolves RAW hazards by forwarding from EX, MEM and WB, or by stalling on load-use.
- Selects the ALU operands and drives operand_a, operand_b and alu_op from registers.
- Uses a valid/ready handshake on both sides, plus a flush input for branch/jump redirect.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction available.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  REG_AW  source indices.
- in_uses_rs1, in_uses_rs2  in  1  source actually read.
- in_rs1_val, in_rs2_val  in  XLEN  register file read data.
- in_imm  in  XLEN  decoded immediate.
- in_a_sel_pc  in  1  operand_a = PC instead of rs1.
- in_b_sel_imm  in  1  operand_b = imm instead of rs2.
- in_alu_op  in  alu_op_t  ALU operation.
- in_rd  in  REG_AW  destination index.
- in_rd_we  in  1  writes rd.
- in_is_load  in  1  load instruction.
- ex_ready  in  1  EX consumes the held instruction.
- flush  in  1  kill held and incoming instruction.
- ex_result  in  XLEN  current ALU result of the held instruction.
- mem_rd  in  REG_AW  MEM stage destination.
- mem_we  in  1  MEM stage write enable.
- mem_data  in  XLEN  MEM write-back value, load data included.
- wb_rd  in  REG_AW  WB stage destination.
- wb_we  in  1  WB stage write enable.
- wb_data  in  XLEN  WB write value.
- out_valid  out  1  held instruction valid.
- operand_a, operand_b  out  XLEN  ALU operands.
- alu_op  out  alu_op_t  ALU operation.
- out_store_data  out  XLEN  forwarded rs2 value.
- out_pc  out  XLEN  held PC.
- out_rd  out  REG_AW  held destination.
- out_rd_we  out  1  held rd write enable.
- out_is_load  out  1  held is a load.
- stall  out  1  hazard stall active this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_rd_we=0, out_is_load=0, stall=0.
  - operand_a, operand_b, out_store_data, out_pc and out_rd = 0.
  - alu_op=ALU_OP_ADD.
  - Reset mid-operation discards the held instruction.
- Acceptance: in_ready = !flush && !hazard && (!out_valid || ex_ready). Transfer occurs when in_valid && in_ready.
- Register update priority:
  1. flush: out_valid<=0 next cycle; incoming instruction dropped.
  2. Transfer: all out_* fields load from the resolved inputs; out_valid<=1.
  3. ex_ready && out_valid with no transfer: out_valid<=0 (bubble); data fields hold.
  4. Otherwise all fields hold.
- Latency: 1 cycle from accept to ALU inputs.
- Source resolution per source s (rs1/rs2) when in_uses_s && s!=0. Priority:
  1. EX: out_valid && out_rd_we && out_rd==s && !out_is_load -> ex_result.
  2. MEM: mem_we && mem_rd==s -> mem_data.
  3. WB: wb_we && wb_rd==s -> wb_data.
  4. No match -> in_s_val.
  - Index 0 never forwards; in_s_val is used.
- Load-use hazard: out_valid && out_is_load && out_rd_we && out_rd!=0 && out_rd matches a used source. Forces in_ready=0 and stall=1 when in_valid. ex_ready then drains the load, leaving a bubble; the instruction issues the next cycle via MEM forwarding.
- Operand select:
  - operand_a = in_a_sel_pc ? in_pc : fwd_rs1.
  - operand_b = in_b_sel_imm ? in_imm : fwd_rs2.
  - out_store_data = fwd_rs2 always.
- Flush together with in_valid: nothing is accepted; stall=0.
- Flush with ex_ready=0: out_valid is still cleared.

Optional Feature:
- Macro ISSUE_FWD_EN.
- Defined: forwarding and the load-use hazard exactly as above.
- Undefined: no forwarding; operands always come from in_s_val. Hazard is any used nonzero source matching either of:
  - (out_valid && out_rd_we && out_rd), or
  - (mem_we && mem_rd), or
  - (wb_we && wb_rd).
  The stage stalls until no match remains. The register file provides write-before-read after WB retires.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, operand_a=0, operand_b=0, alu_op=ALU_OP_ADD immediately; no transfer while held in reset.
- EX forward: issue ADD x5 (result 0x10), then ADD x6=x5+x5 with in_rs1_val=0 -> second instruction has operand_a=operand_b=0x10; no stall.
- Priority: mem_rd=7/mem_data=0xAA and wb_rd=7/wb_data=0xBB with in_rs1=7 -> operand_a=0xAA. With in_rs1=0 and mem_rd=0 -> operand_a=in_rs1_val.
- Load-use: LW x3 held, next uses x3 -> stall=1 and in_ready=0 for 1 cycle, then a bubble (out_valid=0), then issue with operand_a=mem_data.
- Backpressure/flush: ex_ready=0 for 3 cycles -> outputs held and in_ready=0. flush=1 with in_valid=1 -> out_valid=0 next cycle and the instruction is not accepted.
- ISSUE_FWD_EN undefined: dependent ADD after ADD x5 -> stall asserted until x5 leaves WB (3 cycles at full ex_ready); operand taken from in_rs1_val.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: latches a decoded instruction, resolves RAW hazards and drives the ALU operands.
// Compile with ISSUE_FWD_EN defined for EX/MEM/WB forwarding; otherwise the stage stalls on any pending writer.

package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_uses_rs1,
    input  logic              in_uses_rs2,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_a_sel_pc,
    input  logic              in_b_sel_imm,
    input  alu_op_t           in_alu_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    output logic [XLEN-1:0]   operand_a,
    output logic [XLEN-1:0]   operand_b,
    output alu_op_t           alu_op,
    output logic [XLEN-1:0]   out_store_data,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic              stall
);

    logic            hazard;
    logic            transfer;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

`ifdef ISSUE_FWD_EN
    // A held load has no result yet, so it is excluded from EX forwarding and handled as a hazard.
    logic ex_fwd_ok;
    assign ex_fwd_ok = out_valid && out_rd_we && !out_is_load;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fwd_rs1 = in_rs1_val;
        if (in_uses_rs1 && in_rs1 != '0) begin
            if (ex_fwd_ok && out_rd == in_rs1)  fwd_rs1 = ex_result;
            else if (mem_we && mem_rd == in_rs1) fwd_rs1 = mem_data;
            else if (wb_we && wb_rd == in_rs1)   fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        fwd_rs2 = in_rs2_val;
        if (in_uses_rs2 && in_rs2 != '0) begin
            if (ex_fwd_ok && out_rd == in_rs2)  fwd_rs2 = ex_result;
            else if (mem_we && mem_rd == in_rs2) fwd_rs2 = mem_data;
            else if (wb_we && wb_rd == in_rs2)   fwd_rs2 = wb_data;
        end
    end

    assign hazard = out_valid && out_is_load && out_rd_we && (out_rd != '0) &&
                    ((in_uses_rs1 && in_rs1 == out_rd) || (in_uses_rs2 && in_rs2 == out_rd));
`else
    // Without forwarding, any in-flight writer of a used source blocks issue until WB has retired it.
    function automatic logic writer_pending(
        input logic              uses,
        input logic [REG_AW-1:0] idx,
        input logic              e_we,
        input logic [REG_AW-1:0] e_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd
    );
        return uses && (idx != '0) &&
               ((e_we && e_rd == idx) || (m_we && m_rd == idx) || (w_we && w_rd == idx));
    endfunction

    assign hazard = writer_pending(in_uses_rs1, in_rs1, out_valid && out_rd_we, out_rd,
                                   mem_we, mem_rd, wb_we, wb_rd) ||
                    writer_pending(in_uses_rs2, in_rs2, out_valid && out_rd_we, out_rd,
                                   mem_we, mem_rd, wb_we, wb_rd);

    assign fwd_rs1 = in_rs1_val;
    assign fwd_rs2 = in_rs2_val;

    logic unused_fwd_data;
    assign unused_fwd_data = ^{ex_result, mem_data, wb_data};
`endif

    assign in_ready = !flush && !hazard && (!out_valid || ex_ready);
    assign transfer = in_valid && in_ready;
    assign stall    = rst_n && in_valid && hazard && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            operand_a      <= '0;
            operand_b      <= '0;
            alu_op         <= ALU_OP_ADD;
            out_store_data <= '0;
            out_pc         <= '0;
            out_rd         <= '0;
            out_rd_we      <= 1'b0;
            out_is_load    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_valid      <= 1'b1;
            operand_a      <= in_a_sel_pc  ? in_pc  : fwd_rs1;
            operand_b      <= in_b_sel_imm ? in_imm : fwd_rs2;
            alu_op         <= in_alu_op;
            out_store_data <= fwd_rs2;
            out_pc         <= in_pc;
            out_rd         <= in_rd;
            out_rd_we      <= in_rd_we;
            out_is_load    <= in_is_load;
        end else if (ex_ready) begin
            // Held instruction consumed with nothing behind it: leave a bubble, data fields hold.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed hazard scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the issue rules.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_uses_rs1, in_uses_rs2, in_a_sel_pc, in_b_sel_imm, in_rd_we, in_is_load;
    alu_op_t     in_alu_op, alu_op;
    logic        ex_ready, flush;
    logic [31:0] ex_result, mem_data, wb_data;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_we, wb_we;
    logic        out_valid, out_rd_we, out_is_load, stall;
    logic [31:0] operand_a, operand_b, out_store_data, out_pc;
    logic [4:0]  out_rd;

    alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm), .in_alu_op(in_alu_op),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .ex_ready(ex_ready), .flush(flush), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .out_valid(out_valid), .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_load(out_is_load), .stall(stall)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction the stage should be holding.
    logic        m_valid, m_we, m_ld;
    logic [31:0] m_pc, m_a, m_b, m_sd;
    logic [4:0]  m_rd;
    alu_op_t     m_op;

    // Downstream MEM/WB pipeline emulation (used when pipe_mode is set).
    logic        pipe_mode;
    logic        p_mem_we, p_wb_we;
    logic [4:0]  p_mem_rd, p_wb_rd;
    logic [31:0] p_mem_data, p_wb_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_stall, last_ready;
    int          stall_cnt;
    logic [31:0] saved_pc, saved_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_AND:  return a & b;
            ALU_OP_OR:   return a | b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:     return 32'd0;
        endcase
    endfunction

    // Value a source should read, following the spec's EX > MEM > WB > register file priority.
    function automatic logic [31:0] src_val(input logic uses, input logic [4:0] idx, input logic [31:0] rf);
`ifdef ISSUE_FWD_EN
        if (!uses || idx == 5'd0) return rf;
        if (m_valid && m_we && !m_ld && m_rd == idx) return ex_result;
        if (mem_we && mem_rd == idx) return mem_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
`else
        if (uses && idx == 5'd31) return rf;  // register file always supplies the value
        return rf;
`endif
    endfunction

    function automatic logic src_blocked(input logic uses, input logic [4:0] idx);
        if (!uses || idx == 5'd0) return 1'b0;
`ifdef ISSUE_FWD_EN
        return m_valid && m_ld && m_we && m_rd == idx;
`else
        return (m_valid && m_we && m_rd == idx) || (mem_we && mem_rd == idx) || (wb_we && wb_rd == idx);
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_ld = 0; m_pc = 0; m_a = 0; m_b = 0; m_sd = 0; m_rd = 0;
        m_op = ALU_OP_ADD;
    endtask

    task automatic pipe_clear();
        p_mem_we = 0; p_wb_we = 0; p_mem_rd = 0; p_wb_rd = 0; p_mem_data = 0; p_wb_data = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_a_sel_pc = 0; in_b_sel_imm = 0;
        in_alu_op = ALU_OP_ADD; in_rd = 0; in_rd_we = 0; in_is_load = 0;
        ex_ready = 1; flush = 0; mem_we = 0; mem_rd = 0; mem_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_out_valid"}, out_valid, m_valid);
        chk({pfx, "_operand_a"}, operand_a, m_a);
        chk({pfx, "_operand_b"}, operand_b, m_b);
        chk({pfx, "_alu_op"}, alu_op, m_op);
        chk({pfx, "_store_data"}, out_store_data, m_sd);
        chk({pfx, "_out_pc"}, out_pc, m_pc);
        chk({pfx, "_out_rd"}, out_rd, m_rd);
        chk({pfx, "_out_rd_we"}, out_rd_we, m_we);
        chk({pfx, "_out_is_load"}, out_is_load, m_ld);
    endtask

    // One clock: called just after a falling edge with the inputs already set.
    task automatic step(input string pfx);
        logic [31:0] f1, f2, n_mem_data;
        logic        haz, exp_rdy, exp_stall, xfer, n_mem_we;
        logic [4:0]  n_mem_rd;
        if (pipe_mode) begin
            mem_we = p_mem_we; mem_rd = p_mem_rd; mem_data = p_mem_data;
            wb_we = p_wb_we; wb_rd = p_wb_rd; wb_data = p_wb_data;
        end
        ex_result = alu_ref(m_op, m_a, m_b);
        #1;
        haz       = src_blocked(in_uses_rs1, in_rs1) || src_blocked(in_uses_rs2, in_rs2);
        exp_rdy   = !flush && !haz && (!m_valid || ex_ready);
        exp_stall = in_valid && haz && !flush;
        last_stall = stall;
        last_ready = in_ready;
        chk({pfx, "_in_ready"}, in_ready, exp_rdy);
        chk({pfx, "_stall"}, stall, exp_stall);
        xfer = in_valid && exp_rdy;
        f1 = src_val(in_uses_rs1, in_rs1, in_rs1_val);
        f2 = src_val(in_uses_rs2, in_rs2, in_rs2_val);
        n_mem_we   = m_valid && ex_ready && !flush && m_we;
        n_mem_rd   = m_rd;
        n_mem_data = m_ld ? {m_a[15:0], 16'hCAFE} : ex_result;
        @(posedge clk);
        p_wb_we = p_mem_we; p_wb_rd = p_mem_rd; p_wb_data = p_mem_data;
        p_mem_we = n_mem_we; p_mem_rd = n_mem_rd; p_mem_data = n_mem_data;
        if (flush) begin
            m_valid = 0;
        end else if (xfer) begin
            m_valid = 1; m_pc = in_pc;
            m_a = in_a_sel_pc ? in_pc : f1;
            m_b = in_b_sel_imm ? in_imm : f2;
            m_sd = f2; m_op = in_alu_op; m_rd = in_rd; m_we = in_rd_we; m_ld = in_is_load;
        end else if (ex_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic rand_inputs(input bit drive_downstream);
        in_valid     = ($urandom_range(0, 9) < 8);
        in_pc        = $urandom;
        in_rs1       = 5'($urandom_range(0, 3));
        in_rs2       = 5'($urandom_range(0, 3));
        in_uses_rs1  = 1'($urandom_range(0, 1));
        in_uses_rs2  = 1'($urandom_range(0, 1));
        in_rs1_val   = $urandom;
        in_rs2_val   = $urandom;
        in_imm       = $urandom;
        in_a_sel_pc  = ($urandom_range(0, 3) == 0);
        in_b_sel_imm = 1'($urandom_range(0, 1));
        in_alu_op    = alu_op_t'(4'($urandom_range(0, 9)));
        in_rd        = 5'($urandom_range(0, 3));
        in_rd_we     = ($urandom_range(0, 3) != 0);
        in_is_load   = ($urandom_range(0, 3) == 0);
        ex_ready     = ($urandom_range(0, 3) != 0);
        flush        = ($urandom_range(0, 9) == 0);
        if (drive_downstream) begin
            mem_we = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_we  = 1'($urandom_range(0, 1)); wb_rd  = 5'($urandom_range(0, 3)); wb_data  = $urandom;
        end
    endtask

    initial begin
        idle_inputs();
        ex_result = 0;
        rst_n = 0;
        pipe_mode = 0;
        pipe_clear();
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset_stall", stall, 1'b0);
        chk("reset_alu_op_add", alu_op, ALU_OP_ADD);
        @(negedge clk);
        rst_n = 1;

`ifdef ISSUE_FWD_EN
        // EX forwarding: ADD x5 = 8 + 8, then ADD x6 = x5 + x5 with stale register values.
        pipe_mode = 1; pipe_clear();
        idle_inputs();
        in_valid = 1; in_pc = 32'h100; in_uses_rs1 = 1; in_rs1 = 0; in_rs1_val = 8;
        in_b_sel_imm = 1; in_imm = 8; in_rd = 5; in_rd_we = 1;
        step("exfwd_a");
        idle_inputs();
        in_valid = 1; in_pc = 32'h104; in_uses_rs1 = 1; in_uses_rs2 = 1; in_rs1 = 5; in_rs2 = 5;
        in_rd = 6; in_rd_we = 1;
        step("exfwd_b");
        chk("exfwd_no_stall", last_stall, 1'b0);
        chk("exfwd_operand_a", operand_a, 32'h10);
        chk("exfwd_operand_b", operand_b, 32'h10);

        // MEM beats WB for the same index; index 0 never forwards.
        pipe_mode = 0;
        idle_inputs();
        in_valid = 1; in_uses_rs1 = 1; in_rs1 = 7; in_rs1_val = 32'h11;
        mem_we = 1; mem_rd = 7; mem_data = 32'hAA; wb_we = 1; wb_rd = 7; wb_data = 32'hBB;
        step("prio_mem");
        chk("prio_mem_over_wb", operand_a, 32'hAA);
        in_rs1 = 0; mem_rd = 0; wb_rd = 0; in_rs1_val = 32'h33;
        step("prio_x0");
        chk("prio_x0_regfile", operand_a, 32'h33);

        // Load-use: LW x3 then a consumer of x3.
        pipe_mode = 1; pipe_clear();
        idle_inputs();
        in_valid = 1; in_uses_rs1 = 1; in_rs1 = 0; in_rs1_val = 32'h1234;
        in_b_sel_imm = 1; in_imm = 4; in_rd = 3; in_rd_we = 1; in_is_load = 1;
        step("lw_issue");
        idle_inputs();
        in_valid = 1; in_uses_rs1 = 1; in_rs1 = 3; in_rs1_val = 0; in_rd = 4; in_rd_we = 1;
        step("lu_stall");
        chk("lu_stall_seen", last_stall, 1'b1);
        chk("lu_ready_low", last_ready, 1'b0);
        chk("lu_bubble", out_valid, 1'b0);
        step("lu_issue");
        chk("lu_issue_stall", last_stall, 1'b0);
        chk("lu_mem_fwd", operand_a, 32'h1234_CAFE);
`else
        // No forwarding: consumer of x5 waits until x5 has left WB, then reads the register file.
        pipe_mode = 1; pipe_clear();
        idle_inputs();
        in_valid = 1; in_pc = 32'h100; in_uses_rs1 = 1; in_rs1 = 0; in_rs1_val = 8;
        in_b_sel_imm = 1; in_imm = 8; in_rd = 5; in_rd_we = 1;
        step("nofwd_a");
        idle_inputs();
        in_valid = 1; in_pc = 32'h104; in_uses_rs1 = 1; in_rs1 = 5; in_rs1_val = 32'h10;
        in_rd = 6; in_rd_we = 1;
        stall_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step("nofwd_b");
            if (last_stall) stall_cnt++;
            if (last_ready) break;
        end
        chk("nofwd_stall_cycles", stall_cnt, 3);
        chk("nofwd_operand_a", operand_a, 32'h10);
        chk("nofwd_issued", out_valid, 1'b1);
`endif

        // Backpressure: EX not ready holds everything and blocks acceptance.
        pipe_mode = 0;
        idle_inputs();
        in_valid = 1; in_pc = 32'h200; in_a_sel_pc = 1; in_rd = 9; in_rd_we = 1;
        step("bp_load");
        saved_pc = out_pc; saved_a = operand_a;
        idle_inputs();
        in_valid = 1; in_pc = 32'h300; ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold");
            chk("bp_ready_low", last_ready, 1'b0);
        end
        chk("bp_pc_held", out_pc, saved_pc);
        chk("bp_opa_held", operand_a, saved_a);
        flush = 1;
        step("flush");
        chk("flush_valid_low", out_valid, 1'b0);
        chk("flush_stall_low", last_stall, 1'b0);
        chk("flush_not_taken", out_pc, saved_pc);

        // Random traffic: free-running MEM/WB first, then a coherent downstream pipeline.
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            step("rnd_free");
        end
        pipe_mode = 1; pipe_clear();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b0);
            step("rnd_pipe");
        end

        // Reset mid-stream: clears immediately and blocks transfers while asserted.
        rand_inputs(1'b1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_opa", operand_a, 32'h0);
        chk("mid_rst_opb", operand_b, 32'h0);
        chk("mid_rst_alu_op", alu_op, ALU_OP_ADD);
        chk("mid_rst_stall", stall, 1'b0);
        model_reset();
        pipe_clear();
        in_valid = 1; flush = 0; ex_ready = 1;
        @(posedge clk);
        #1;
        check_outputs("in_rst");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 200; i++) begin
            rand_inputs(1'b0);
            step("rnd_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
